md_ctrl: RTL and testbench

Sequencing controller for the shared multiply/divide unit in the EX stage. It accepts MULT/MULTU/DIV/DIVU requests from the pipeline and drives the unit's one-hot op and operands. It waits for the unit's completion strobe and owns the architectural HI/LO registers. It also produces the pipeline stall for HI/LO hazards, applies MTHI/MTLO, and handles exception flush and a completion watchdog.

---
 rtl/md_ctrl_if.sv | 40 ++++
 rtl/md_ctrl.sv | 108 ++++++++++
 tb/tb_md_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/md_ctrl_if.sv
// Request, operand, completion and HI/LO signals between the EX pipeline,
// the md_ctrl sequencer and the shared multiply/divide unit.
interface md_ctrl_if;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic        req_ready;
   logic        flush;
   logic        mf_req;
   logic        mthi_we;
   logic        mtlo_we;
   logic [31:0] mt_wdata;
   logic [3:0]  md_op;
   logic [31:0] md_src1;
   logic [31:0] md_src2;
   logic [63:0] md_result;
   logic        md_en;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        md_timeout;
   logic [1:0]  fsm_state;

   // Handshake: a request transfers in a cycle where req_valid and req_ready
   // are both high; req_ready depends combinationally on req_valid and flush.
   modport slave (
      input  req_valid, req_op, req_src1, req_src2, flush, mf_req,
             mthi_we, mtlo_we, mt_wdata, md_result, md_en,
      output req_ready, md_op, md_src1, md_src2, stall, hi, lo,
             md_timeout, fsm_state
   );

   modport master (
      output req_valid, req_op, req_src1, req_src2, flush, mf_req,
             mthi_we, mtlo_we, mt_wdata, md_result, md_en,
      input  req_ready, md_op, md_src1, md_src2, stall, hi, lo,
             md_timeout, fsm_state
   );
endinterface

// File: rtl/md_ctrl.sv
// Sequencer for the shared multiply/divide unit: issues one-hot ops, waits for
// completion, owns HI/LO, drives HI/LO hazard stalls and a completion watchdog.
module md_ctrl #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input logic     clk,
   input logic     resetn,
   md_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       md_op;
   logic [31:0]      md_src1;
   logic [31:0]      md_src2;
   logic [31:0]      hi;
   logic [31:0]      lo;
   logic [3:0]       op_hot;
   logic             is_idle;
   logic             accept;
   logic             mt_ok;
   logic             timeout_hit;

   always_comb begin
      op_hot = 4'b0000;
      case (bus.req_op)
         2'd0: op_hot = 4'b0100;
         2'd1: op_hot = 4'b1000;
         2'd2: op_hot = 4'b0001;
         2'd3: op_hot = 4'b0010;
         default: op_hot = 4'b0000;
      endcase
   end

   assign is_idle = (state == IDLE);
   assign accept  = is_idle & bus.req_valid & ~bus.flush;
   assign mt_ok   = is_idle & ~bus.flush;
   // Flush and completion both outrank the watchdog in the final BUSY cycle.
   assign timeout_hit = (state == BUSY) & ~bus.flush & ~bus.md_en & (cnt == LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         cnt     <= '0;
         md_op   <= 4'b0000;
         md_src1 <= '0;
         md_src2 <= '0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mt_ok && bus.mthi_we) hi <= bus.mt_wdata;
               if (mt_ok && bus.mtlo_we) lo <= bus.mt_wdata;
               if (accept) begin
                  md_op   <= op_hot;
                  md_src1 <= bus.req_src1;
                  md_src2 <= bus.req_src2;
                  cnt     <= '0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (bus.flush) begin
                  md_op <= 4'b0000;
                  state <= DRAIN;
               end else if (bus.md_en) begin
                  hi    <= bus.md_result[63:32];
                  lo    <= bus.md_result[31:0];
                  md_op <= 4'b0000;
                  state <= IDLE;
               end else if (cnt == LAST) begin
                  md_op <= 4'b0000;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               state <= IDLE;
            end
            default: begin
               md_op <= 4'b0000;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = accept;
   assign bus.stall      = ~is_idle & (bus.mf_req | bus.mthi_we | bus.mtlo_we | bus.req_valid);
   assign bus.md_op      = md_op;
   assign bus.md_src1    = md_src1;
   assign bus.md_src2    = md_src2;
   assign bus.hi         = hi;
   assign bus.lo         = lo;
   assign bus.md_timeout = timeout_hit;
   assign bus.fsm_state  = state;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: the multiply/divide unit is played by the
// stimulus itself, with hand-computed results and expected HI/LO values.
module tb_md_ctrl;

   logic clk;
   logic resetn;
   int   checks;
   int   failures;

   md_ctrl_if bus ();

   md_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_valid = 1'b0;
      bus.req_op    = 2'd0;
      bus.req_src1  = '0;
      bus.req_src2  = '0;
      bus.flush     = 1'b0;
      bus.mf_req    = 1'b0;
      bus.mthi_we   = 1'b0;
      bus.mtlo_we   = 1'b0;
      bus.mt_wdata  = '0;
      bus.md_result = '0;
      bus.md_en     = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_src1  = a;
      bus.req_src2  = b;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      clear_inputs();
      resetn = 1'b0;
      #12;
      chk("reset_md_op", 64'(bus.md_op), 64'h0);
      chk("reset_hilo", {bus.hi, bus.lo}, 64'h0);
      chk("reset_src", {bus.md_src1, bus.md_src2}, 64'h0);
      chk("reset_state", 64'(bus.fsm_state), 64'd0);
      chk("reset_timeout", 64'(bus.md_timeout), 64'd0);
      resetn = 1'b1;
      tick();

      // MULT -2 * 3
      issue(2'd0, 32'hFFFF_FFFE, 32'd3);
      #1;
      chk("mult_ready", {63'd0, bus.req_ready}, 64'd1);
      chk("mult_accept_nostall", {63'd0, bus.stall}, 64'd0);
      tick();
      bus.req_valid = 1'b0;
      #1;
      chk("mult_busy1", {bus.fsm_state, bus.md_op}, {58'd0, 2'd1, 4'b0100});
      chk("mult_src", {bus.md_src1, bus.md_src2}, 64'hFFFF_FFFE_0000_0003);
      tick();
      bus.md_en     = 1'b1;
      bus.md_result = 64'hFFFF_FFFF_FFFF_FFFA;
      #1;
      chk("mult_busy2_op", 64'(bus.md_op), 64'h4);
      tick();
      bus.md_result = 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      chk("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      chk("mult_idle", {bus.fsm_state, bus.md_op}, 64'h0);
      tick();
      bus.md_en = 1'b0;
      #1;
      chk("md_en_echo_ignored", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);

      // DIVU 100 / 7, unit completes in its 33rd BUSY cycle
      issue(2'd3, 32'd100, 32'd7);
      #1;
      chk("divu_ready", {63'd0, bus.req_ready}, 64'd1);
      tick();
      bus.req_valid = 1'b0;
      bus.mf_req    = 1'b1;
      for (int i = 1; i <= 33; i++) begin
         if (i == 33) begin
            bus.md_en     = 1'b1;
            bus.md_result = {32'd2, 32'd14};
         end
         #1;
         chk($sformatf("divu_busy_c%0d", i), {bus.md_op, bus.stall}, {59'd0, 4'b0010, 1'b1});
         tick();
      end
      bus.md_en = 1'b0;
      #1;
      chk("divu_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});
      chk("divu_mf_nostall", {63'd0, bus.stall}, 64'd0);
      chk("divu_idle", 64'(bus.fsm_state), 64'd0);
      bus.mf_req = 1'b0;

      // Preload HI/LO, then flush a DIV in its 10th BUSY cycle
      bus.mthi_we  = 1'b1;
      bus.mt_wdata = 32'hA5A5_A5A5;
      tick();
      bus.mthi_we  = 1'b0;
      bus.mtlo_we  = 1'b1;
      bus.mt_wdata = 32'h5A5A_5A5A;
      tick();
      bus.mtlo_we = 1'b0;
      #1;
      chk("mt_preload", {bus.hi, bus.lo}, 64'hA5A5_A5A5_5A5A_5A5A);
      issue(2'd2, 32'd50, 32'd5);
      tick();
      bus.req_valid = 1'b0;
      for (int i = 1; i <= 9; i++) tick();
      bus.flush     = 1'b1;
      bus.md_en     = 1'b1;
      bus.md_result = 64'h1111_2222_3333_4444;
      issue(2'd0, 32'd1, 32'd1);
      #1;
      chk("flush_busy_op", 64'(bus.md_op), 64'h1);
      chk("flush_busy_refuse", {bus.req_ready, bus.stall}, {62'd0, 2'b01});
      tick();
      bus.flush = 1'b0;
      bus.md_en = 1'b0;
      #1;
      chk("drain_state", {bus.fsm_state, bus.md_op}, {58'd0, 2'd2, 4'b0000});
      chk("drain_refuse", {bus.req_ready, bus.stall}, {62'd0, 2'b01});
      bus.flush    = 1'b1;
      bus.mthi_we  = 1'b1;
      bus.mt_wdata = 32'h0;
      tick();
      #1;
      chk("flush_hilo_kept", {bus.hi, bus.lo}, 64'hA5A5_A5A5_5A5A_5A5A);
      chk("flush_idle_refuse", {bus.fsm_state, bus.req_ready}, 64'd0);
      tick();
      clear_inputs();
      #1;
      chk("flush_idle_mt_suppressed", {bus.hi, bus.lo}, 64'hA5A5_A5A5_5A5A_5A5A);
      chk("flush_idle_no_accept", 64'(bus.fsm_state), 64'd0);

      // Watchdog: unit never completes
      issue(2'd3, 32'd1, 32'd1);
      tick();
      bus.req_valid = 1'b0;
      for (int i = 1; i <= 63; i++) begin
         #1;
         chk($sformatf("wd_busy_c%0d", i), {bus.fsm_state, bus.md_timeout}, {61'd0, 2'd1, 1'b0});
         tick();
      end
      #1;
      chk("wd_pulse", {bus.md_timeout, bus.md_op}, {59'd0, 1'b1, 4'b0010});
      tick();
      #1;
      chk("wd_drain", {bus.fsm_state, bus.md_timeout, bus.md_op}, {57'd0, 2'd2, 1'b0, 4'b0000});
      tick();
      #1;
      chk("wd_idle", {bus.fsm_state, bus.md_timeout}, 64'd0);
      chk("wd_hilo_kept", {bus.hi, bus.lo}, 64'hA5A5_A5A5_5A5A_5A5A);

      // MTLO and MULTU accepted in the same IDLE cycle
      bus.mtlo_we  = 1'b1;
      bus.mt_wdata = 32'h0000_1234;
      issue(2'd1, 32'h0001_0000, 32'h0001_0000);
      #1;
      chk("multu_ready", {63'd0, bus.req_ready}, 64'd1);
      tick();
      clear_inputs();
      #1;
      chk("multu_mt_first", {bus.hi, bus.lo}, 64'hA5A5_A5A5_0000_1234);
      chk("multu_op", 64'(bus.md_op), 64'h8);
      tick();
      bus.md_en     = 1'b1;
      bus.md_result = 64'h0000_0001_0000_0000;
      tick();
      bus.md_en = 1'b0;
      #1;
      chk("multu_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);

      // Asynchronous reset in the middle of a DIV
      issue(2'd2, 32'd9, 32'd3);
      tick();
      bus.req_valid = 1'b0;
      tick();
      #1;
      chk("div_pre_reset_op", 64'(bus.md_op), 64'h1);
      resetn = 1'b0;
      #1;
      chk("async_reset_op", 64'(bus.md_op), 64'h0);
      chk("async_reset_hilo", {bus.hi, bus.lo}, 64'h0);
      chk("async_reset_src", {bus.md_src1, bus.md_src2}, 64'h0);
      chk("async_reset_state", 64'(bus.fsm_state), 64'd0);
      resetn = 1'b1;
      issue(2'd0, 32'd7, 32'd6);
      #1;
      chk("post_reset_ready", {63'd0, bus.req_ready}, 64'd1);
      tick();
      bus.req_valid = 1'b0;
      #1;
      chk("post_reset_op", 64'(bus.md_op), 64'h4);
      tick();
      bus.md_en     = 1'b1;
      bus.md_result = 64'd42;
      tick();
      bus.md_en = 1'b0;
      #1;
      chk("post_reset_hilo", {bus.hi, bus.lo}, 64'd42);
      chk("post_reset_idle", 64'(bus.fsm_state), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
